cp0: RTL and testbench
======================

# cp0

Coprocessor-0 exception controller for the five-stage MIPS pipeline; sits at the MEM stage directly upstream of the pipeline-flush logic. Holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against MEM-stage exceptions, and raises the single `Exception` pulse that clears IF/ID, ID/EX, EX/MEM and MEM/WB. It also services `mtc0`/`mfc0` and `eret`.

## Interface
- `PRID_VAL`, 32'h4D49_5053, constant returned for PRId (reg 15)
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `PC_M`  in  32  PC of the instruction in MEM
- `BD_M`  in  1  MEM instruction sits in a branch delay slot
- `ExcValid_M`  in  1  MEM instruction carries a synchronous exception
- `ExcCode_M`  in  5  code for that exception
- `HWInt`  in  6  external interrupt lines, level-sensitive
- `WE`  in  1  `mtc0` in MEM
- `A`  in  5  CP0 register number for read and write
- `DIn`  in  32  `mtc0` write data
- `eret_M`  in  1  `eret` in MEM
- `DOut`  out  32  `mfc0` read data, combinational
- `EPC`  out  32  current EPC, word aligned, feeds NPC on `eret`
- `Exception`  out  1  take exception or interrupt this cycle; drives the flush block

## Operation
- SR(12) fields:
  - `IM[15:10]`, `EXL[1]`, `IE[0]`; other bits read 0.
- Cause(13) fields:
  - `BD[31]`.
  - `IP[15:10]`: loaded from `HWInt` every cycle, not writable.
  - `ExcCode[6:2]`.
  - Other bits read 0.
- EPC(14): `[31:2]` stored, `[1:0]` read 0.
- PRId(15): reads `PRID_VAL`.
- Other addresses read 0 and ignore writes.
- Request logic:
  - `IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL`
  - `ExcReq = ExcValid_M & ~SR.EXL`
  - `Exception = (IntReq | ExcReq) & ~reset`
- Priority: interrupt over synchronous exception. Interrupt records ExcCode 0; otherwise ExcCode_M is recorded.
- On an edge with `Exception` = 1:
  - `SR.EXL` <= 1
  - `Cause.ExcCode` <= winning code
  - `Cause.BD` <= `BD_M`
  - `EPC` <= `BD_M ? PC_M-4 : PC_M`, with `[1:0]` forced 0
- Two-state view, held in `SR.EXL`:
  - NORMAL (EXL=0) -> HANDLER on `Exception`.
  - HANDLER -> NORMAL on `eret_M`.
  - In HANDLER all new requests are masked.
- `mtc0` (`WE`=1, `Exception`=0): writes SR, EPC or the writable Cause fields (none) at `A`.
- Simultaneous events:
  - `Exception` with `WE` or `eret_M`: exception update wins; the write or eret belongs to a squashed instruction and is dropped.
  - `WE` to SR together with `eret_M`: eret clears EXL after the write, so EXL ends 0.
- Reads: `DOut` shows the register value before any same-cycle write, with no bypass. `IP` reflects the current `HWInt`.

## Timing
- `Exception` is combinational from the MEM inputs and current state. It is valid in the same cycle, so flush and CP0 update share one edge.
- CP0 register updates are visible on `DOut`/`EPC` one cycle later.
- Reset, synchronous:
  - SR=0, Cause=0, EPC=0.
  - `Exception`=0 while `reset` is high, even if `ExcValid_M`=1.
  - `DOut` reflects the reset registers from the next cycle.
- Reset asserted in HANDLER returns to NORMAL; pending requests are dropped.
- `HWInt` is not latched. A request that deasserts before being taken is lost.

## Structure
- Shared package `mips_cp0_pkg` holds:
  - Register numbers 12/13/14/15.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - The handler entry constant 32'h0000_4180 used by NPC.
- One natural sub-module, `cp0_arb`: combinational request/priority/code select, so it can be unit-tested apart from the register file.

## Test plan
1. Reset with `ExcValid_M`=1 -> `Exception`=0. After release, `DOut` for A=12/13/14 is 0 and for A=15 is `PRID_VAL`.
2. `mtc0` SR=32'h0000_FC01, then `HWInt`=6'b000100, `PC_M`=32'h0000_3010, `BD_M`=0:
   - `Exception`=1 in the same cycle.
   - Next cycle: EPC=32'h0000_3010, Cause.ExcCode=0, `SR.EXL`=1, Cause.IP=6'b000100.
3. Exception in a delay slot: `ExcValid_M`=1, `ExcCode_M`=12, `BD_M`=1, `PC_M`=32'h0000_3024 -> EPC=32'h0000_3020, Cause=32'h8000_0030.
4. With EXL=1, `HWInt`=6'h3F and `ExcValid_M`=1 -> `Exception` stays 0. Then `eret_M`=1 -> EXL=0 next cycle and the interrupt fires the following cycle.
5. Same cycle: `ExcValid_M`=1 (code 10), `WE`=1, A=14, `DIn`=32'hDEAD_BEEF -> EPC equals `PC_M`, not DEAD_BEEC.
6. Same cycle: interrupt and `ExcValid_M` (code 4) -> recorded ExcCode=0.

Source files
------------

// File: rtl/mips_cp0_pkg.sv
// rtl/mips_cp0_pkg.sv - shared CP0 register numbers, field positions and exception codes
package mips_cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EC_LO = 2;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_BD    = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/cp0_arb.sv
// rtl/cp0_arb.sv - combinational interrupt/exception request arbitration
//
// Ports:
//   hw_int, im, ie, exl : interrupt lines and SR mask/enable state
//   exc_valid, exc_code_in : synchronous exception from MEM
//   reset               : suppresses any request while high
//   exception           : take exception/interrupt this cycle
//   exc_code_out        : code to record (interrupt beats synchronous exception)
module cp0_arb
    import mips_cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic       exc_valid,
    input  logic [4:0] exc_code_in,
    input  logic       reset,
    output logic       exception,
    output logic [4:0] exc_code_out
);

    logic int_req;
    logic exc_req;

    assign int_req      = (|(hw_int & im)) & ie & ~exl;
    assign exc_req      = exc_valid & ~exl;
    assign exception    = (int_req | exc_req) & ~reset;
    assign exc_code_out = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0.sv
// rtl/cp0.sv - MIPS coprocessor-0 exception controller (SR, Cause, EPC, PRId)
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   PC_M, BD_M          : MEM-stage PC and delay-slot flag
//   ExcValid_M, ExcCode_M : MEM-stage synchronous exception
//   HWInt               : level-sensitive interrupt lines
//   WE, A, DIn          : mtc0 write enable, register number, data (A also selects mfc0 read)
//   eret_M              : eret in MEM
//   DOut                : mfc0 read data (combinational, pre-write value)
//   EPC                 : current EPC, word aligned
//   Exception           : flush/trap pulse
module cp0
    import mips_cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic        ExcValid_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        WE,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        eret_M,
    output logic [31:0] DOut,
    output logic [31:0] EPC,
    output logic        Exception
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc_code;
    logic [31:0] epc_q;
    logic [4:0]  win_code;
    logic [31:0] epc_next;

    cp0_arb u_arb (
        .hw_int       (HWInt),
        .im           (sr_im),
        .ie           (sr_ie),
        .exl          (sr_exl),
        .exc_valid    (ExcValid_M),
        .exc_code_in  (ExcCode_M),
        .reset        (reset),
        .exception    (Exception),
        .exc_code_out (win_code)
    );

    // A faulting delay-slot instruction restarts at its branch.
    assign epc_next = BD_M ? (PC_M - 32'd4) : PC_M;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im          <= '0;
            sr_exl         <= 1'b0;
            sr_ie          <= 1'b0;
            cause_bd       <= 1'b0;
            cause_exc_code <= '0;
            epc_q          <= '0;
        end else if (Exception) begin
            // Any concurrent mtc0/eret belongs to a squashed instruction.
            sr_exl         <= 1'b1;
            cause_exc_code <= win_code;
            cause_bd       <= BD_M;
            epc_q          <= epc_next & 32'hFFFF_FFFC;
        end else begin
            if (WE) begin
                case (A)
                    REG_SR: begin
                        sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
                        sr_exl <= DIn[SR_EXL];
                        sr_ie  <= DIn[SR_IE];
                    end
                    REG_EPC: epc_q <= DIn & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            // Placed after the write so eret clears EXL even when SR is written too.
            if (eret_M) begin
                sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A)
            REG_SR:    DOut = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            REG_CAUSE: DOut = {cause_bd, 15'b0, HWInt, 3'b0, cause_exc_code, 2'b0};
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = '0;
        endcase
    end

    assign EPC = epc_q;

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - scoreboard bench for cp0
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_M;
    logic        BD_M;
    logic        ExcValid_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        WE;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        eret_M;
    logic [31:0] DOut;
    logic [31:0] EPC;
    logic        Exception;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .PC_M       (PC_M),
        .BD_M       (BD_M),
        .ExcValid_M (ExcValid_M),
        .ExcCode_M  (ExcCode_M),
        .HWInt      (HWInt),
        .WE         (WE),
        .A          (A),
        .DIn        (DIn),
        .eret_M     (eret_M),
        .DOut       (DOut),
        .EPC        (EPC),
        .Exception  (Exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0 DOut, 1 EPC, 2 Exception
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are settled mid-cycle; drain everything queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                0:       act = DOut;
                1:       act = EPC;
                default: act = {31'b0, Exception};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; PC_M = 32'h0; BD_M = 1'b0; ExcValid_M = 1'b1; ExcCode_M = 5'd12;
        HWInt = 6'b0; WE = 1'b0; A = 5'd12; DIn = 32'h0; eret_M = 1'b0;

        // 1: reset suppresses Exception, then reset values readable
        cyc(); expect_val("exc_in_reset", 2, 32'd0);
        cyc(); reset = 1'b0; ExcValid_M = 1'b0; A = 5'd12;
        expect_val("rst_sr", 0, 32'h0); expect_val("rst_exc_idle", 2, 32'd0);
        cyc(); A = 5'd13; expect_val("rst_cause", 0, 32'h0);
        cyc(); A = 5'd14; expect_val("rst_epc", 0, 32'h0);
        cyc(); A = 5'd15; expect_val("prid", 0, PRID);

        // 2: mtc0 SR then interrupt
        cyc(); WE = 1'b1; A = 5'd12; DIn = 32'h0000_FC01;
        expect_val("mtc0_sr_preread", 0, 32'h0); expect_val("mtc0_no_exc", 2, 32'd0);
        cyc(); WE = 1'b0; HWInt = 6'b000100; PC_M = 32'h0000_3010; BD_M = 1'b0;
        expect_val("sr_after_write", 0, 32'h0000_FC01); expect_val("int_fires", 2, 32'd1);
        cyc(); A = 5'd13;
        expect_val("int_masked_exl", 2, 32'd0); expect_val("int_epc", 1, 32'h0000_3010);
        expect_val("int_cause", 0, 32'h0000_1000);
        cyc(); HWInt = 6'b0; A = 5'd12; expect_val("sr_exl_set", 0, 32'h0000_FC03);

        // 3: exception in a delay slot
        cyc(); eret_M = 1'b1; expect_val("eret_no_exc", 2, 32'd0);
        cyc(); eret_M = 1'b0; ExcValid_M = 1'b1; ExcCode_M = 5'd12; BD_M = 1'b1; PC_M = 32'h0000_3024;
        expect_val("sr_after_eret", 0, 32'h0000_FC01); expect_val("ov_fires", 2, 32'd1);
        cyc(); ExcValid_M = 1'b0; BD_M = 1'b0; A = 5'd13;
        expect_val("bd_epc", 1, 32'h0000_3020); expect_val("bd_cause", 0, 32'h8000_0030);

        // 4: everything masked in handler; eret re-opens the interrupt
        cyc(); HWInt = 6'h3F; ExcValid_M = 1'b1; ExcCode_M = 5'd10;
        expect_val("handler_masked", 2, 32'd0);
        cyc(); ExcValid_M = 1'b0; eret_M = 1'b1; A = 5'd12;
        expect_val("eret_cycle_masked", 2, 32'd0); expect_val("eret_cycle_sr", 0, 32'h0000_FC03);
        cyc(); eret_M = 1'b0; PC_M = 32'h0000_3040;
        expect_val("post_eret_sr", 0, 32'h0000_FC01); expect_val("post_eret_int", 2, 32'd1);
        cyc(); HWInt = 6'b0; A = 5'd13;
        expect_val("int2_epc", 1, 32'h0000_3040); expect_val("int2_cause", 0, 32'h0);

        // 5: exception beats same-cycle mtc0 to EPC
        cyc(); eret_M = 1'b1; expect_val("eret2_no_exc", 2, 32'd0);
        cyc(); eret_M = 1'b0; ExcValid_M = 1'b1; ExcCode_M = 5'd10; WE = 1'b1; A = 5'd14;
        DIn = 32'hDEAD_BEEF; PC_M = 32'h0000_3050;
        expect_val("ri_fires", 2, 32'd1); expect_val("epc_preread", 0, 32'h0000_3040);
        cyc(); ExcValid_M = 1'b0; WE = 1'b0; A = 5'd13;
        expect_val("ri_epc_not_dropped_write", 1, 32'h0000_3050); expect_val("ri_cause", 0, 32'h0000_0028);

        // 6: interrupt beats synchronous exception
        cyc(); eret_M = 1'b1; expect_val("eret3_no_exc", 2, 32'd0);
        cyc(); eret_M = 1'b0; HWInt = 6'b000001; ExcValid_M = 1'b1; ExcCode_M = 5'd4; PC_M = 32'h0000_3060;
        expect_val("int_vs_adel_fires", 2, 32'd1);
        cyc(); ExcValid_M = 1'b0;
        expect_val("int_vs_adel_cause", 0, 32'h0000_0400); expect_val("int_vs_adel_epc", 1, 32'h0000_3060);
        expect_val("int_vs_adel_masked", 2, 32'd0);

        // mtc0 SR with EXL=1 plus eret: EXL ends 0
        cyc(); HWInt = 6'b0; WE = 1'b1; A = 5'd12; DIn = 32'h0000_FC03; eret_M = 1'b1;
        cyc(); WE = 1'b0; eret_M = 1'b0; expect_val("wr_eret_exl0", 0, 32'h0000_FC01);

        // EPC write aligns; unmapped write ignored
        cyc(); WE = 1'b1; A = 5'd14; DIn = 32'h1234_5677;
        cyc(); WE = 1'b1; A = 5'd20; DIn = 32'hFFFF_FFFF;
        expect_val("epc_aligned", 1, 32'h1234_5674); expect_val("unmapped_read", 0, 32'h0);
        cyc(); WE = 1'b0; A = 5'd20; expect_val("unmapped_still0", 0, 32'h0);

        // reset inside handler returns to NORMAL
        cyc(); ExcValid_M = 1'b1; ExcCode_M = 5'd5; A = 5'd12; expect_val("ades_fires", 2, 32'd1);
        cyc(); ExcValid_M = 1'b0; expect_val("handler_sr", 0, 32'h0000_FC03);
        cyc(); reset = 1'b1; HWInt = 6'h3F; expect_val("reset_blocks_exc", 2, 32'd0);
        cyc(); reset = 1'b0; HWInt = 6'b0; expect_val("reset_sr0", 0, 32'h0);
        expect_val("reset_epc0", 1, 32'h0);

        cyc();
        cyc();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
